// File: rtl/alu_seq_mul.sv
// Parametrised add/subtract/multiply unit with a full 2*W-bit result.
// Add, subtract and the reserved opcode finish in one edge; multiply is a W-step shift-add.
module alu_seq_mul #(
    parameter int W  = 6,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     sl,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] c,
    output logic           borrow,
    output logic           err
);

    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    MUL      = 1'b1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    logic [0:0]     state_reg;
    logic [CW-1:0]  count_reg;
    logic [2*W-1:0] acc_reg;
    logic [2*W-1:0] mcand_reg;
    logic [W-1:0]   mplier_reg;
    logic [2*W-1:0] c_reg;
    logic           done_reg;
    logic           borrow_reg;
    logic           err_reg;

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] acc_next;

    assign a_ext = {{W{1'b0}}, a};
    assign b_ext = {{W{1'b0}}, b};

    // Accumulator value after the current iteration; also the product on the last one.
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            c_reg      <= '0;
            done_reg   <= 1'b0;
            borrow_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        case (sl)
                            2'b00: begin
                                c_reg      <= a_ext + b_ext;
                                borrow_reg <= 1'b0;
                                err_reg    <= 1'b0;
                                done_reg   <= 1'b1;
                            end
                            2'b01: begin
                                // 2W-bit wraparound gives the sign-extended difference.
                                c_reg      <= a_ext - b_ext;
                                borrow_reg <= (a < b);
                                err_reg    <= 1'b0;
                                done_reg   <= 1'b1;
                            end
                            2'b10: begin
                                c_reg      <= '0;
                                borrow_reg <= 1'b0;
                                err_reg    <= 1'b1;
                                done_reg   <= 1'b1;
                            end
                            default: begin
                                state_reg  <= MUL;
                                acc_reg    <= '0;
                                count_reg  <= '0;
                                mcand_reg  <= a_ext;
                                mplier_reg <= b;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 1'b1;
                    if (count_reg == LAST_CNT) begin
                        c_reg      <= acc_next;
                        done_reg   <= 1'b1;
                        borrow_reg <= 1'b0;
                        err_reg    <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = (state_reg == MUL);
    assign done   = done_reg;
    assign c      = c_reg;
    assign borrow = borrow_reg;
    assign err    = err_reg;

endmodule
